// File: rtl/cmd_phy_if.sv
// Command-control <-> cmd_phy handshake bundle: command request and response return.
interface cmd_phy_if;
    // command request (command control -> cmd_phy)
    logic        iStrobe;
    logic [37:0] iCmd;
    logic        iResp_expected;
    logic        oAck;
    // response return (cmd_phy -> command control)
    logic        oStrobe_resp;
    logic [37:0] oResponse;
    logic        oCrc_err;
    logic        oTimeout;
    logic        iAck_resp;

    modport master (
        output iStrobe, iCmd, iResp_expected, iAck_resp,
        input  oAck, oStrobe_resp, oResponse, oCrc_err, oTimeout
    );

    modport slave (
        input  iStrobe, iCmd, iResp_expected, iAck_resp,
        output oAck, oStrobe_resp, oResponse, oCrc_err, oTimeout
    );
endinterface

// File: rtl/cmd_phy.sv
// SD CMD-line physical stage: frames a 38-bit command with CRC7, shifts it out
// MSB first, then optionally captures and checks a 48-bit response.
module cmd_phy #(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic       iClock_host,
    input  logic       iReset,
    cmd_phy_if.slave   bus,
    output logic       oCmd_out,
    output logic       oCmd_oe,
    input  logic       iCmd_in,
    output logic       oIdle
);

    localparam int unsigned WAIT_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
    localparam logic [WAIT_W-1:0] NCR_LAST = WAIT_W'(NCR_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_START,
        RECV,
        CHECK,
        DONE
    } state_t;

    state_t state, nextState;

    logic [37:0]       cmdLat;
    logic              respExp;
    logic [47:0]       frame;
    logic [5:0]        bitCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic [46:0]       rx;
    logic [37:0]       resp;
    logic              crcErr;
    logic              timeout;

    // Serial CRC7 (x^7 + x^3 + 1, seed 0) over 40 bits, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = data[39 - i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // State register.
    always_ff @(posedge iClock_host) begin
        if (iReset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        nextState        = state;
        bus.oAck         = 1'b0;
        bus.oStrobe_resp = 1'b0;
        oCmd_oe          = 1'b0;
        oCmd_out         = 1'b1;
        oIdle            = 1'b0;
        case (state)
            IDLE: begin
                oIdle = 1'b1;
                if (bus.iStrobe) nextState = LOAD;
            end
            LOAD: begin
                bus.oAck  = 1'b1;
                nextState = SEND;
            end
            SEND: begin
                oCmd_oe  = 1'b1;
                oCmd_out = frame[47];
                if (bitCnt == '0) nextState = respExp ? WAIT_START : DONE;
            end
            WAIT_START: begin
                if (!iCmd_in)                 nextState = RECV;
                else if (waitCnt == NCR_LAST) nextState = DONE;
            end
            RECV: begin
                if (bitCnt == '0) nextState = CHECK;
            end
            CHECK: nextState = DONE;
            DONE: begin
                bus.oStrobe_resp = 1'b1;
                if (bus.iAck_resp) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: command latch, frame shifter, wait counter, response capture and check.
    always_ff @(posedge iClock_host) begin
        if (iReset) begin
            cmdLat  <= '0;
            respExp <= 1'b0;
            frame   <= '1;
            bitCnt  <= '0;
            waitCnt <= '0;
            rx      <= '0;
            resp    <= '0;
            crcErr  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iStrobe) begin
                        cmdLat  <= bus.iCmd;
                        respExp <= bus.iResp_expected;
                    end
                end
                LOAD: begin
                    frame  <= {1'b0, 1'b1, cmdLat, crc7({2'b01, cmdLat}), 1'b1};
                    bitCnt <= 6'd47;
                end
                SEND: begin
                    frame   <= {frame[46:0], 1'b1};
                    bitCnt  <= bitCnt - 1'b1;
                    waitCnt <= '0;
                    if (bitCnt == '0) begin
                        resp    <= '0;
                        crcErr  <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                WAIT_START: begin
                    waitCnt <= waitCnt + 1'b1;
                    bitCnt  <= 6'd46;
                    if (iCmd_in && waitCnt == NCR_LAST) begin
                        timeout <= 1'b1;
                        resp    <= '0;
                    end
                end
                RECV: begin
                    rx     <= {rx[45:0], iCmd_in};
                    bitCnt <= bitCnt - 1'b1;
                end
                CHECK: begin
                    // CRC is evaluated over the captured bits with the consumed
                    // start bit (always 0) re-inserted as the leading bit.
                    resp    <= rx[45:8];
                    crcErr  <= (crc7({1'b0, rx[46:8]}) != rx[7:1]) || rx[46] || !rx[0];
                    timeout <= 1'b0;
                end
                DONE: begin
                    if (bus.iAck_resp) begin
                        crcErr  <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oResponse = resp;
    assign bus.oCrc_err  = crcErr;
    assign bus.oTimeout  = timeout;

endmodule

// File: tb/tb_cmd_phy.sv
// Directed bench for cmd_phy: command framing, response capture, CRC error,
// timeout, reset mid-send and strobe rejection outside IDLE.
module tb_cmd_phy;

    localparam int unsigned NCR_MAX = 64;

    logic iClock_host = 1'b0;
    logic iReset      = 1'b1;
    logic oCmd_out;
    logic oCmd_oe;
    logic iCmd_in     = 1'b1;
    logic oIdle;

    int nVec  = 0;
    int nMiss = 0;

    cmd_phy_if bus ();

    cmd_phy #(.NCR_MAX(NCR_MAX)) dut (
        .iClock_host (iClock_host),
        .iReset      (iReset),
        .bus         (bus.slave),
        .oCmd_out    (oCmd_out),
        .oCmd_oe     (oCmd_oe),
        .iCmd_in     (iCmd_in),
        .oIdle       (oIdle)
    );

    always #5 iClock_host = ~iClock_host;

    task automatic tick();
        @(posedge iClock_host);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 = no response, 1 = card responds 5 cycles after release, 2 = card silent
    task automatic runCmd(input logic [37:0] cmd, input logic rexp, input logic [47:0] frameExp,
                          input int mode, input logic [47:0] respFrame,
                          input logic [37:0] expResp, input logic expCrc, input logic expTo,
                          input int ackDelay, input logic poke);
        logic [47:0] got;
        logic        oeAll;
        logic [37:0] held;
        got   = '0;
        oeAll = 1'b1;
        checkValue("idle_before", {63'd0, oIdle}, 64'd1);
        // cycle 0
        bus.iStrobe        = 1'b1;
        bus.iCmd           = cmd;
        bus.iResp_expected = rexp;
        tick();
        // cycle 1
        checkValue("ack_cycle1", {63'd0, bus.oAck}, 64'd1);
        bus.iStrobe = 1'b0;
        tick();
        // cycles 2..49
        for (int i = 0; i < 48; i++) begin
            got[47 - i] = oCmd_out;
            oeAll       = oeAll & oCmd_oe;
            if (poke && i == 10) begin
                bus.iStrobe = 1'b1;
                bus.iCmd    = 38'h3F_FFFF_FFFF;
            end
            if (poke && i == 11) begin
                checkValue("no_ack_send", {63'd0, bus.oAck}, 64'd0);
                bus.iStrobe = 1'b0;
                bus.iCmd    = cmd;
            end
            tick();
        end
        // cycle 50
        checkValue("frame", {16'd0, got}, {16'd0, frameExp});
        checkValue("oe_during_send", {63'd0, oeAll}, 64'd1);
        if (mode == 0) begin
            checkValue("strobe_c50", {63'd0, bus.oStrobe_resp}, 64'd1);
        end else if (mode == 1) begin
            checkValue("released_c50", {62'd0, oCmd_oe, oCmd_out}, 64'd1);
            for (int k = 0; k < 5; k++) begin
                iCmd_in = 1'b1;
                if (poke && k == 1) begin
                    bus.iStrobe = 1'b1;
                    bus.iCmd    = 38'h3F_FFFF_FFFF;
                end
                if (poke && k == 2) begin
                    checkValue("no_ack_wait", {63'd0, bus.oAck}, 64'd0);
                    bus.iStrobe = 1'b0;
                    bus.iCmd    = cmd;
                end
                tick();
            end
            // cycles 55..102: start bit then 47 response bits
            for (int i = 0; i < 48; i++) begin
                iCmd_in = respFrame[47 - i];
                tick();
            end
            iCmd_in = 1'b1;
            // cycle 103: CHECK
            checkValue("no_strobe_check", {63'd0, bus.oStrobe_resp}, 64'd0);
            tick();
            // cycle 104: DONE
            checkValue("strobe_c104", {63'd0, bus.oStrobe_resp}, 64'd1);
        end else begin
            iCmd_in = 1'b1;
            for (int t = 0; t < int'(NCR_MAX) - 1; t++) tick();
            checkValue("no_strobe_pre_to", {63'd0, bus.oStrobe_resp}, 64'd0);
            tick();
            checkValue("strobe_timeout", {63'd0, bus.oStrobe_resp}, 64'd1);
        end
        checkValue("response", {26'd0, bus.oResponse}, {26'd0, expResp});
        checkValue("crc_err", {63'd0, bus.oCrc_err}, {63'd0, expCrc});
        checkValue("timeout", {63'd0, bus.oTimeout}, {63'd0, expTo});
        held = bus.oResponse;
        for (int d = 0; d < ackDelay; d++) begin
            tick();
            checkValue("hold_strobe", {63'd0, bus.oStrobe_resp}, 64'd1);
            checkValue("hold_resp", {26'd0, bus.oResponse}, {26'd0, expResp});
            checkValue("hold_flags", {62'd0, bus.oCrc_err, bus.oTimeout}, {62'd0, expCrc, expTo});
        end
        bus.iAck_resp = 1'b1;
        tick();
        bus.iAck_resp = 1'b0;
        checkValue("idle_after", {63'd0, oIdle}, 64'd1);
        checkValue("flags_cleared", {61'd0, bus.oStrobe_resp, bus.oCrc_err, bus.oTimeout}, 64'd0);
        checkValue("resp_kept", {26'd0, bus.oResponse}, {26'd0, held});
    endtask

    initial begin
        bus.iStrobe        = 1'b0;
        bus.iCmd           = '0;
        bus.iResp_expected = 1'b0;
        bus.iAck_resp      = 1'b0;
        iReset             = 1'b1;
        tick();
        tick();
        checkValue("rst_outputs",
                   {57'd0, bus.oAck, oCmd_out, oCmd_oe, bus.oStrobe_resp, bus.oCrc_err, bus.oTimeout, oIdle},
                   {57'd0, 7'b0100001});
        checkValue("rst_response", {26'd0, bus.oResponse}, 64'd0);
        iReset = 1'b0;
        tick();

        // reset during SEND at cycle 20
        bus.iStrobe        = 1'b1;
        bus.iCmd           = 38'h08_0000_01AA;
        bus.iResp_expected = 1'b1;
        tick();
        bus.iStrobe = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        checkValue("sending_c20", {63'd0, oCmd_oe}, 64'd1);
        iReset = 1'b1;
        tick();
        checkValue("rst_mid_send", {61'd0, oCmd_oe, oCmd_out, oIdle}, {61'd0, 3'b011});
        iReset = 1'b0;

        // CMD0, no response
        runCmd(38'h00_0000_0000, 1'b0, 48'h40_0000_0000_95, 0, 48'h0,
               38'h0, 1'b0, 1'b0, 0, 1'b0);
        // CMD8 with good R7 response, strobes poked during SEND/WAIT_START, delayed ack
        runCmd(38'h08_0000_01AA, 1'b1, 48'h48_0000_01AA_87, 1, 48'h08_0000_01AA_13,
               38'h08_0000_01AA, 1'b0, 1'b0, 10, 1'b1);
        // CMD8 with corrupted response CRC
        runCmd(38'h08_0000_01AA, 1'b1, 48'h48_0000_01AA_87, 1, 48'h08_0000_01AA_15,
               38'h08_0000_01AA, 1'b1, 1'b0, 0, 1'b0);
        // CMD17, card silent -> timeout
        runCmd(38'h11_0000_0000, 1'b1, 48'h51_0000_0000_55, 2, 48'h0,
               38'h0, 1'b0, 1'b1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
